// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - request/grant stream to sky130 1rw1r SRAM macro array controller
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   init_done_o          high once requests are accepted
//   mem_req_i/gnt_o      per-bank request handshake (addr, wdata, strb, we)
//   mem_rvalid_o         per-bank response valid, RD_LATENCY cycles after accept
//   mem_rdata_o/err_o    response data / out-of-range flag
//   sram_*_o, sram_dout_i  macro port 0 signals, NUM_MACROS macros per bank
module sram_bank_ctrl #(
   parameter int NUM_PORTS  = 1,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MACRO_AW   = 9,
   parameter int NUM_MACROS = 2,
   parameter int RD_LATENCY = 1,
   parameter int INIT_ZERO  = 1
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   output logic                                          init_done_o,
   input  logic [NUM_PORTS-1:0]                          mem_req_i,
   output logic [NUM_PORTS-1:0]                          mem_gnt_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]               mem_addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]               mem_wdata_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]             mem_strb_i,
   input  logic [NUM_PORTS-1:0]                          mem_we_i,
   output logic [NUM_PORTS-1:0]                          mem_rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]               mem_rdata_o,
   output logic [NUM_PORTS-1:0]                          mem_err_o,
   output logic [NUM_PORTS*NUM_MACROS-1:0]               sram_csb_o,
   output logic [NUM_PORTS*NUM_MACROS-1:0]               sram_web_o,
   output logic [NUM_PORTS*NUM_MACROS*DATA_WIDTH/8-1:0]  sram_wmask_o,
   output logic [NUM_PORTS*NUM_MACROS*MACRO_AW-1:0]      sram_addr_o,
   output logic [NUM_PORTS*NUM_MACROS*DATA_WIDTH-1:0]    sram_din_o,
   input  logic [NUM_PORTS*NUM_MACROS*DATA_WIDTH-1:0]    sram_dout_i
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(NUM_PORTS * BYTES);
   localparam int SEL_W  = $clog2(NUM_MACROS);
   localparam int SEL_WS = (SEL_W == 0) ? 1 : SEL_W;
   localparam int WORD_W = ADDR_WIDTH - OFF;
   localparam int USED_W = MACRO_AW + SEL_W;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t              state_q;
   logic [MACRO_AW-1:0] cnt_q;
   logic                gnt_q;
   logic                done_q;
   logic                init_active;

   // Shared init FSM: zero-fill every row of every macro once after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         if (INIT_ZERO != 0) begin
            state_q <= ST_INIT;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state_q <= ST_READY;
            gnt_q   <= 1'b1;
            done_q  <= 1'b1;
         end
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= ST_READY;
                  gnt_q   <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               gnt_q  <= 1'b1;
               done_q <= 1'b1;
            end
         endcase
      end
   end

   // Outputs take their reset values for the whole time rst_i is high,
   // including the first cycle before the registers have been cleared.
   assign init_active = (state_q == ST_INIT) && !rst_i;
   assign init_done_o = rst_i ? (INIT_ZERO == 0) : done_q;
   assign mem_gnt_o   = rst_i ? {NUM_PORTS{INIT_ZERO == 0}} : {NUM_PORTS{gnt_q}};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_bank
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_W-1:0]     word;
      logic [MACRO_AW-1:0]   row;
      logic [SEL_WS-1:0]     sel;
      logic                  oor;
      logic                  acc;
      logic                  unused_addr;

      assign addr        = mem_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign word        = addr[ADDR_WIDTH-1:OFF];
      assign row         = word[MACRO_AW-1:0];
      assign unused_addr = ^addr;
      assign acc         = mem_req_i[p] && gnt_q && !rst_i;

      if (SEL_W > 0) begin : g_sel
         assign sel = word[MACRO_AW +: SEL_W];
      end else begin : g_nosel
         assign sel = '0;
      end

      // Power-of-two macro count: out of range iff any bit above the decoded range is set.
      if (WORD_W > USED_W) begin : g_oor
         assign oor = |word[WORD_W-1:USED_W];
      end else begin : g_nooor
         assign oor = 1'b0;
      end

      for (genvar m = 0; m < NUM_MACROS; m++) begin : g_macro
         localparam int F = p * NUM_MACROS + m;
         always_comb begin
            sram_csb_o[F]                        = 1'b1;
            sram_web_o[F]                        = 1'b1;
            sram_wmask_o[F*BYTES +: BYTES]       = '0;
            sram_addr_o[F*MACRO_AW +: MACRO_AW]  = '0;
            sram_din_o[F*DATA_WIDTH +: DATA_WIDTH] = '0;
            if (init_active) begin
               sram_csb_o[F]                       = 1'b0;
               sram_web_o[F]                       = 1'b0;
               sram_wmask_o[F*BYTES +: BYTES]      = '1;
               sram_addr_o[F*MACRO_AW +: MACRO_AW] = cnt_q;
            end else if (acc && !oor && (sel == SEL_WS'(m))) begin
               sram_csb_o[F]                          = 1'b0;
               sram_web_o[F]                          = !mem_we_i[p];
               sram_wmask_o[F*BYTES +: BYTES]         = mem_strb_i[p*BYTES +: BYTES];
               sram_addr_o[F*MACRO_AW +: MACRO_AW]    = row;
               sram_din_o[F*DATA_WIDTH +: DATA_WIDTH] = mem_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end

      // Control pipe: valid/err travel the full latency; we/sel are only
      // needed at stage 0 where the macro output is selected.
      logic [RD_LATENCY-1:0] v_q;
      logic [RD_LATENCY-1:0] err_q;
      logic                  we0_q;
      logic [SEL_WS-1:0]     sel0_q;
      logic [DATA_WIDTH-1:0] rd0;
      logic [DATA_WIDTH-1:0] rdata;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            v_q    <= '0;
            err_q  <= '0;
            we0_q  <= 1'b0;
            sel0_q <= '0;
         end else begin
            v_q[0]   <= acc;
            err_q[0] <= acc && oor;
            we0_q    <= mem_we_i[p];
            sel0_q   <= sel;
            for (int k = 1; k < RD_LATENCY; k++) begin
               v_q[k]   <= v_q[k-1];
               err_q[k] <= err_q[k-1];
            end
         end
      end

      // Zeroing here covers writes, out-of-range and idle cycles in one place.
      always_comb begin
         rd0 = '0;
         if (v_q[0] && !we0_q && !err_q[0]) begin
            for (int m = 0; m < NUM_MACROS; m++) begin
               if (sel0_q == SEL_WS'(m))
                  rd0 = sram_dout_i[(p*NUM_MACROS+m)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end

      if (RD_LATENCY == 1) begin : g_lat1
         assign rdata = rd0;
      end else begin : g_latn
         logic [DATA_WIDTH-1:0] d_q [1:RD_LATENCY-1];
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int k = 1; k < RD_LATENCY; k++) d_q[k] <= '0;
            end else begin
               d_q[1] <= rd0;
               for (int k = 2; k < RD_LATENCY; k++) d_q[k] <= d_q[k-1];
            end
         end
         assign rdata = d_q[RD_LATENCY-1];
      end

      assign mem_rvalid_o[p] = v_q[RD_LATENCY-1] && !rst_i;
      assign mem_err_o[p]    = v_q[RD_LATENCY-1] && err_q[RD_LATENCY-1] && !rst_i;
      assign mem_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rst_i ? '0 : rdata;
   end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - scoreboard bench for sram_bank_ctrl
module tb_sram_bank_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        init_done_o;
   logic [0:0]  mem_req_i;
   logic [0:0]  mem_gnt_o;
   logic [12:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_strb_i;
   logic [0:0]  mem_we_i;
   logic [0:0]  mem_rvalid_o;
   logic [31:0] mem_rdata_o;
   logic [0:0]  mem_err_o;
   logic [1:0]  sram_csb_o;
   logic [1:0]  sram_web_o;
   logic [7:0]  sram_wmask_o;
   logic [17:0] sram_addr_o;
   logic [63:0] sram_din_o;
   logic [63:0] sram_dout_i;

   sram_bank_ctrl #(
      .NUM_PORTS(1), .ADDR_WIDTH(13), .DATA_WIDTH(32), .MACRO_AW(9),
      .NUM_MACROS(2), .RD_LATENCY(2), .INIT_ZERO(1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .init_done_o(init_done_o),
      .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i), .mem_we_i(mem_we_i),
      .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
      .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
      .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural macro pair: registered read, byte-masked write.
   logic [31:0] smem [2][512];
   logic [31:0] sdout [2];
   assign sram_dout_i = {sdout[1], sdout[0]};

   always @(posedge clk_i) begin
      for (int m = 0; m < 2; m++) begin
         if (!sram_csb_o[m]) begin
            if (!sram_web_o[m]) begin
               for (int b = 0; b < 4; b++)
                  if (sram_wmask_o[m*4+b])
                     smem[m][sram_addr_o[m*9 +: 9]][b*8 +: 8] <= sram_din_o[m*32+b*8 +: 8];
            end else begin
               sdout[m] <= smem[m][sram_addr_o[m*9 +: 9]];
            end
         end
      end
   end

   // Scoreboard: reference word array plus queue of expected responses.
   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [1024];

   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && mem_rvalid_o[0]) begin
         if (sb_q.size() == 0) begin
            check("spurious_rvalid", 64'(mem_rvalid_o), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("rsp_latency", 64'(cyc), 64'(e.cyc + 2));
            check("rsp_rdata", 64'(mem_rdata_o), 64'(e.data));
            check("rsp_err", 64'(mem_err_o), 64'(e.err));
         end
      end
   end

   task automatic do_req(input logic [12:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] sb, input logic expect_resp);
      logic [10:0] word;
      logic        oor;
      logic        sel;
      logic [8:0]  row;
      exp_t        e;
      mem_req_i   = 1'b1;
      mem_addr_i  = a;
      mem_we_i    = we;
      mem_wdata_i = wd;
      mem_strb_i  = sb;
      word = a[12:2];
      oor  = word[10];
      sel  = word[9];
      row  = word[8:0];
      @(negedge clk_i);
      check("gnt", 64'(mem_gnt_o), 64'd1);
      check("csb", 64'(sram_csb_o), oor ? 64'h3 : (sel ? 64'h1 : 64'h2));
      if (!oor) begin
         check("row", 64'(sram_addr_o[sel*9 +: 9]), 64'(row));
         check("web", 64'(sram_web_o[sel]), 64'(!we));
      end
      if (expect_resp) begin
         e.cyc  = cyc;
         e.err  = oor;
         e.data = 32'd0;
         if (!oor) begin
            if (we) begin
               for (int b = 0; b < 4; b++)
                  if (sb[b]) ref_mem[word[9:0]][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
               e.data = ref_mem[word[9:0]];
            end
         end
         sb_q.push_back(e);
      end
      @(posedge clk_i);
      #1;
      mem_req_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
      rst_i = 1'b1;
      mem_req_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_strb_i = '0; mem_we_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_gnt", 64'(mem_gnt_o), 64'd0);
      check("rst_done", 64'(init_done_o), 64'd0);
      check("rst_rvalid", 64'(mem_rvalid_o), 64'd0);
      check("rst_csb", 64'(sram_csb_o), 64'h3);
      check("rst_web", 64'(sram_web_o), 64'h3);
      check("rst_rdata_err", {31'd0, mem_err_o, mem_rdata_o}, 64'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      // A request during zero-fill must never be accepted.
      mem_req_i = 1'b1; mem_addr_i = 13'h004;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk_i);
         check("init_gnt", 64'(mem_gnt_o), 64'd0);
         check("init_ctl", {60'd0, sram_csb_o, sram_web_o}, 64'd0);
         check("init_addr", 64'(sram_addr_o), 64'({i[8:0], i[8:0]}));
         if (sram_din_o != 64'd0 || sram_wmask_o != 8'hFF)
            check("init_din_mask", {sram_din_o[31:0], 24'd0, sram_wmask_o}, 64'hFF);
         @(posedge clk_i);
      end
      #1;
      mem_req_i = 1'b0;
      @(negedge clk_i);
      check("done", 64'(init_done_o), 64'd1);
      check("ready_gnt", 64'(mem_gnt_o), 64'd1);
      @(posedge clk_i);
      #1;

      do_req(13'h004, 1'b1, 32'hA5A5_1234, 4'hF, 1'b1);
      do_req(13'h004, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h804, 1'b1, 32'h1111_8804, 4'hF, 1'b1);
      do_req(13'h000, 1'b1, 32'h0000_0C00, 4'hF, 1'b1);
      do_req(13'h008, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);
      do_req(13'h008, 1'b1, 32'h1234_5678, 4'h5, 1'b1);
      do_req(13'h80C, 1'b1, 32'h2222_880C, 4'hF, 1'b1);
      do_req(13'h0FFC, 1'b1, 32'h7777_0FFC, 4'hF, 1'b1);
      repeat (3) @(posedge clk_i);
      #1;
      do_req(13'h804, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h0FFC, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h1000, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h000, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h804, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h008, 1'b0, 32'd0, 4'h0, 1'b1);
      do_req(13'h80C, 1'b0, 32'd0, 4'h0, 1'b1);
      repeat (4) @(posedge clk_i);
      #1;
      check("drain", 64'(sb_q.size()), 64'd0);

      // Reset one cycle after accepting a read: the response must vanish.
      do_req(13'h004, 1'b0, 32'd0, 4'h0, 1'b0);
      rst_i = 1'b1;
      repeat (2) begin
         @(negedge clk_i);
         check("mid_rst_rvalid", 64'(mem_rvalid_o), 64'd0);
         check("mid_rst_csb", 64'(sram_csb_o), 64'h3);
         check("mid_rst_gnt", 64'(mem_gnt_o), 64'd0);
         @(posedge clk_i);
      end
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("reinit_addr0", 64'(sram_addr_o), 64'd0);
      check("reinit_done", 64'(init_done_o), 64'd0);
      @(negedge clk_i);
      check("reinit_addr1", 64'(sram_addr_o), 64'({9'd1, 9'd1}));
      repeat (4) @(negedge clk_i);
      check("final_queue", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
